// File: rtl/conv_stream_engine.sv
// Sequential single-MAC 2-D convolution engine with synchronous memory read ports
// and a valid/ready result write port; one output element per BIAS-MAC-DRAIN-WRITE pass.
module conv_stream_engine #(
  parameter int D_IN       = 1,
  parameter int H_IN       = 5,
  parameter int W_IN       = 5,
  parameter int N_FILTERS  = 64,
  parameter int H_FILT     = 3,
  parameter int W_FILT     = 3,
  parameter int STRIDE     = 1,
  parameter int PADDING    = 2,
  parameter int DILATION   = 2,
  parameter int DATA_WIDTH = 18,
  parameter int FRAC_WIDTH = 8,
  parameter int ACC_WIDTH  = 48,
  localparam int H_OUT = (H_IN + 2*PADDING - DILATION*(H_FILT-1) - 1)/STRIDE + 1,
  localparam int W_OUT = (W_IN + 2*PADDING - DILATION*(W_FILT-1) - 1)/STRIDE + 1,
  localparam int K     = D_IN*H_FILT*W_FILT,
  localparam int XAW   = (D_IN*H_IN*W_IN > 1) ? $clog2(D_IN*H_IN*W_IN) : 1,
  localparam int WAW   = (N_FILTERS*K > 1) ? $clog2(N_FILTERS*K) : 1,
  localparam int BAW   = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1,
  localparam int YAW   = (N_FILTERS*H_OUT*W_OUT > 1) ? $clog2(N_FILTERS*H_OUT*W_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  x_rd_en,
  output logic [XAW-1:0]        x_rd_addr,
  input  logic [DATA_WIDTH-1:0] x_rd_data,
  output logic                  w_rd_en,
  output logic [WAW-1:0]        w_rd_addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  output logic                  b_rd_en,
  output logic [BAW-1:0]        b_rd_addr,
  input  logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [YAW-1:0]        y_addr,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic [2:0]            state_dbg
);

  // Handshake: a result transfers on every rising edge where y_valid and y_ready
  // are both high; once raised, y_valid/y_addr/y_data stay put until that edge.

  localparam int OYW = (H_OUT > 1) ? $clog2(H_OUT) : 1;
  localparam int OXW = (W_OUT > 1) ? $clog2(W_OUT) : 1;
  localparam int CW  = (D_IN > 1) ? $clog2(D_IN) : 1;
  localparam int KYW = (H_FILT > 1) ? $clog2(H_FILT) : 1;
  localparam int KXW = (W_FILT > 1) ? $clog2(W_FILT) : 1;

  localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) << (FRAC_WIDTH-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, next_state;

  logic [BAW-1:0] f_cnt;
  logic [OYW-1:0] oy_cnt;
  logic [OXW-1:0] ox_cnt;
  logic [CW-1:0]  c_cnt;
  logic [KYW-1:0] ky_cnt;
  logic [KXW-1:0] kx_cnt;

  logic                          relu_q;
  logic                          pend_valid;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   rnd_sum;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]         res;

  logic signed [31:0] iy, ix;
  logic tap_in_range, first_tap, last_tap, last_out;
  logic kx_last, ky_last, c_last, ox_last, oy_last, f_last;

  // Tap position in input coordinates; negative or too-large means padding.
  assign iy = $signed(32'(oy_cnt))*STRIDE - PADDING + $signed(32'(ky_cnt))*DILATION;
  assign ix = $signed(32'(ox_cnt))*STRIDE - PADDING + $signed(32'(kx_cnt))*DILATION;
  assign tap_in_range = (iy >= 0) && (iy < H_IN) && (ix >= 0) && (ix < W_IN);

  assign kx_last   = (kx_cnt == KXW'(W_FILT-1));
  assign ky_last   = (ky_cnt == KYW'(H_FILT-1));
  assign c_last    = (c_cnt == CW'(D_IN-1));
  assign ox_last   = (ox_cnt == OXW'(W_OUT-1));
  assign oy_last   = (oy_cnt == OYW'(H_OUT-1));
  assign f_last    = (f_cnt == BAW'(N_FILTERS-1));
  assign first_tap = (c_cnt == '0) && (ky_cnt == '0) && (kx_cnt == '0);
  assign last_tap  = c_last && ky_last && kx_last;
  assign last_out  = f_last && oy_last && ox_last;

  assign prod     = $signed(x_rd_data) * $signed(w_rd_data);
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){b_rd_data[DATA_WIDTH-1]}}, b_rd_data};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    b_rd_en    = 1'b0;
    x_rd_en    = 1'b0;
    w_rd_en    = 1'b0;
    y_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_BIAS;
      end
      S_BIAS: begin
        busy       = 1'b1;
        b_rd_en    = 1'b1;
        next_state = S_MAC;
      end
      S_MAC: begin
        busy    = 1'b1;
        x_rd_en = tap_in_range;
        w_rd_en = tap_in_range;
        if (last_tap) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        busy       = 1'b1;
        next_state = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        y_valid = 1'b1;
        if (y_ready) next_state = last_out ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Addresses read as zero whenever their port is idle.
  always_comb begin
    x_rd_addr = '0;
    w_rd_addr = '0;
    b_rd_addr = '0;
    y_addr    = '0;
    if (x_rd_en)
      x_rd_addr = XAW'(($signed(32'(c_cnt))*H_IN + iy)*W_IN + ix);
    if (w_rd_en)
      w_rd_addr = WAW'(((32'(f_cnt)*D_IN + 32'(c_cnt))*H_FILT + 32'(ky_cnt))*W_FILT
                       + 32'(kx_cnt));
    if (b_rd_en)
      b_rd_addr = f_cnt;
    if (y_valid)
      y_addr = YAW'((32'(f_cnt)*H_OUT + 32'(oy_cnt))*W_OUT + 32'(ox_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_cnt      <= '0;
      oy_cnt     <= '0;
      ox_cnt     <= '0;
      c_cnt      <= '0;
      ky_cnt     <= '0;
      kx_cnt     <= '0;
      acc        <= '0;
      pend_valid <= 1'b0;
      relu_q     <= 1'b0;
    end else begin
      pend_valid <= (state == S_MAC) && tap_in_range;

      if (state == S_IDLE && start) begin
        relu_q <= relu_en;
        f_cnt  <= '0;
        oy_cnt <= '0;
        ox_cnt <= '0;
      end

      // Product of the tap issued last cycle lands one cycle behind the issue.
      if (state == S_MAC) begin
        if (first_tap)       acc <= bias_ext <<< FRAC_WIDTH;
        else if (pend_valid) acc <= acc + prod_ext;

        if (kx_last) begin
          kx_cnt <= '0;
          if (ky_last) begin
            ky_cnt <= '0;
            if (c_last) c_cnt <= '0;
            else        c_cnt <= c_cnt + CW'(1);
          end else begin
            ky_cnt <= ky_cnt + KYW'(1);
          end
        end else begin
          kx_cnt <= kx_cnt + KXW'(1);
        end
      end

      if (state == S_DRAIN && pend_valid) acc <= acc + prod_ext;

      if (state == S_WRITE && y_ready) begin
        if (ox_last) begin
          ox_cnt <= '0;
          if (oy_last) begin
            oy_cnt <= '0;
            if (f_last) f_cnt <= '0;
            else        f_cnt <= f_cnt + BAW'(1);
          end else begin
            oy_cnt <= oy_cnt + OYW'(1);
          end
        end else begin
          ox_cnt <= ox_cnt + OXW'(1);
        end
      end
    end
  end

  // Round half up, saturate to the data range, then optional ReLU.
  always_comb begin
    rnd_sum = acc + RND;
    shifted = rnd_sum >>> FRAC_WIDTH;
    if (shifted > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
    else                        res = shifted[DATA_WIDTH-1:0];
    if (relu_q && res[DATA_WIDTH-1]) res = '0;
  end

  assign y_data    = y_valid ? res : '0;
  assign state_dbg = state;

endmodule
